// File: rtl/io_pkg.sv
// Shared KEY/SW device constants: register addresses and CTRL register layout.
// The processor's address decode imports the same values.
package io_pkg;
  localparam logic [31:0] IO_ADDR_KDATA = 32'hFFFF_F080;
  localparam logic [31:0] IO_ADDR_KCTRL = 32'hFFFF_F084;
  localparam logic [31:0] IO_ADDR_SDATA = 32'hFFFF_F090;
  localparam logic [31:0] IO_ADDR_SCTRL = 32'hFFFF_F094;

  localparam int CTRL_RDY = 0;
  localparam int CTRL_OVR = 2;
  localparam int CTRL_IE  = 8;

  typedef struct packed {
    logic [22:0] rsv_hi;
    logic        ie;
    logic [4:0]  rsv_mid;
    logic        ovr;
    logic        rsv_lo;
    logic        rdy;
  } ctrl_reg_t;

  function automatic ctrl_reg_t pack_ctrl(input logic ie, input logic ovr, input logic rdy);
    ctrl_reg_t c;
    c     = '0;
    c.ie  = ie;
    c.ovr = ovr;
    c.rdy = rdy;
    return c;
  endfunction
endpackage

// File: rtl/io_key_sw_device_if.sv
// Data-bus port of a memory-mapped IO responder (processor M-stage side).
interface io_key_sw_device_if #(
   parameter int DBITS = 32
);
   logic [DBITS-1:0] addr;
   logic             rd;
   logic             wr;
   logic [DBITS-1:0] wdata;
   logic [DBITS-1:0] rdata;
   logic             hit;

   modport master (output addr, rd, wr, wdata, input rdata, hit);
   modport slave  (input addr, rd, wr, wdata, output rdata, hit);
endinterface

// File: rtl/io_key_sw_device_input_debounce.sv
// Two-flop synchroniser plus stability counter; DATA follows the input only after
// it has held one value for CYCLES clocks. change pulses on the updating cycle.
module input_debounce #(
   parameter int WIDTH  = 1,
   parameter int CYCLES = 100000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] data,
   output logic             change
);
   localparam int CW = $clog2(CYCLES + 1);
   localparam logic [CW-1:0] CMAX = CW'(CYCLES);

   logic [WIDTH-1:0] sync1, sync2, last;
   logic [CW-1:0]    cnt, cnt_nxt;

   // Any difference between consecutive samples restarts the count; saturate at CMAX.
   always_comb begin
      if (sync2 != last)     cnt_nxt = '0;
      else if (cnt == CMAX)  cnt_nxt = cnt;
      else                   cnt_nxt = cnt + 1'b1;
   end

   assign change = (cnt_nxt == CMAX) && (sync2 != data);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
         last  <= '0;
         cnt   <= '0;
         data  <= '0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
         last  <= sync2;
         cnt   <= cnt_nxt;
         if (change) data <= sync2;
      end
   end
endmodule

// File: rtl/io_key_sw_device.sv
// KEY/SW memory-mapped responder: debounced DATA registers, CTRL registers with
// sticky ready/overrun, combinational read data and an interrupt request.
module io_key_sw_device
   import io_pkg::*;
#(
   parameter int          DBITS           = 32,
   parameter int          KEYBITS         = 4,
   parameter int          SWBITS          = 10,
   parameter int          DEBOUNCE_CYCLES = 100000,
   parameter logic [31:0] ADDRKDATA       = IO_ADDR_KDATA,
   parameter logic [31:0] ADDRKCTRL       = IO_ADDR_KCTRL,
   parameter logic [31:0] ADDRSDATA       = IO_ADDR_SDATA,
   parameter logic [31:0] ADDRSCTRL       = IO_ADDR_SCTRL
) (
   input  logic               clk,
   input  logic               reset,
   io_key_sw_device_if.slave  bus,
   input  logic [KEYBITS-1:0] key_n,
   input  logic [SWBITS-1:0]  sw,
   output logic               irq
);
   logic [KEYBITS-1:0] kdata;
   logic [SWBITS-1:0]  sdata;
   logic               kchg, schg;
   logic               kready, kovr, kie;
   logic               sready, sovr, sie;

   input_debounce #(.WIDTH(KEYBITS), .CYCLES(DEBOUNCE_CYCLES)) u_key (
      .clk(clk), .reset(reset), .din(~key_n), .data(kdata), .change(kchg)
   );
   input_debounce #(.WIDTH(SWBITS), .CYCLES(DEBOUNCE_CYCLES)) u_sw (
      .clk(clk), .reset(reset), .din(sw), .data(sdata), .change(schg)
   );

   logic hit_kd, hit_kc, hit_sd, hit_sc;
   assign hit_kd = (bus.addr == DBITS'(ADDRKDATA));
   assign hit_kc = (bus.addr == DBITS'(ADDRKCTRL));
   assign hit_sd = (bus.addr == DBITS'(ADDRSDATA));
   assign hit_sc = (bus.addr == DBITS'(ADDRSCTRL));

   logic krd, srd, kwr, swr, ovr_clr;
   assign krd     = bus.rd && hit_kd;
   assign srd     = bus.rd && hit_sd;
   assign kwr     = bus.wr && hit_kc;
   assign swr     = bus.wr && hit_sc;
   assign ovr_clr = !bus.wdata[CTRL_OVR];

   // A change event wins over both a DATA read (ready) and an overrun-clear write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         kready <= 1'b0;
         kovr   <= 1'b0;
         kie    <= 1'b0;
         sready <= 1'b0;
         sovr   <= 1'b0;
         sie    <= 1'b0;
      end else begin
         if (kchg)               kready <= 1'b1;
         else if (krd)           kready <= 1'b0;
         if (kchg && kready)     kovr   <= 1'b1;
         else if (kwr && ovr_clr && !kchg) kovr <= 1'b0;
         if (kwr)                kie    <= bus.wdata[CTRL_IE];

         if (schg)               sready <= 1'b1;
         else if (srd)           sready <= 1'b0;
         if (schg && sready)     sovr   <= 1'b1;
         else if (swr && ovr_clr && !schg) sovr <= 1'b0;
         if (swr)                sie    <= bus.wdata[CTRL_IE];
      end
   end

   assign irq = (kready && kie) || (sready && sie);

   always_comb begin
      bus.rdata = '0;
      bus.hit   = 1'b1;
      if (hit_kd)      bus.rdata = DBITS'(kdata);
      else if (hit_kc) bus.rdata = DBITS'(pack_ctrl(kie, kovr, kready));
      else if (hit_sd) bus.rdata = DBITS'(sdata);
      else if (hit_sc) bus.rdata = DBITS'(pack_ctrl(sie, sovr, sready));
      else             bus.hit   = 1'b0;
   end

   logic unused_wdata;
   assign unused_wdata = ^bus.wdata;
endmodule

// File: tb/tb_io_key_sw_device.sv
// Directed bench for io_key_sw_device with a short debounce window.
module tb_io_key_sw_device;
   localparam logic [31:0] KD = 32'hFFFF_F080;
   localparam logic [31:0] KC = 32'hFFFF_F084;
   localparam logic [31:0] SD = 32'hFFFF_F090;
   localparam logic [31:0] SC = 32'hFFFF_F094;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] key_n;
   logic [9:0] sw;
   logic       irq;
   int         n_checks = 0;
   int         n_fail   = 0;

   io_key_sw_device_if #(.DBITS(32)) bus ();

   io_key_sw_device #(.DBITS(32), .KEYBITS(4), .SWBITS(10), .DEBOUNCE_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .bus(bus), .key_n(key_n), .sw(sw), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic peek(input logic [31:0] a, output logic [31:0] d);
      bus.addr = a; bus.rd = 1'b0; bus.wr = 1'b0;
      #1 d = bus.rdata;
   endtask

   task automatic rd_strobe(input logic [31:0] a, output logic [31:0] d);
      @(negedge clk);
      bus.addr = a; bus.rd = 1'b1;
      #1 d = bus.rdata;
      @(posedge clk); #1;
      bus.rd = 1'b0;
   endtask

   task automatic wr_strobe(input logic [31:0] a, input logic [31:0] v);
      @(negedge clk);
      bus.addr = a; bus.wdata = v; bus.wr = 1'b1;
      @(posedge clk); #1;
      bus.wr = 1'b0;
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset_initial();
      logic [31:0] d;
      reset = 1'b1; key_n = 4'hF; sw = '0;
      bus.addr = '0; bus.rd = 1'b0; bus.wr = 1'b0; bus.wdata = '0;
      wait_clks(3);
      peek(KC, d);
      n_checks++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL reset_kctrl got %h want %h", d, 32'h0); end
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", irq); end
      @(negedge clk) reset = 1'b0;
      wait_clks(8);
   endtask

   task automatic test_sw_data();
      logic [31:0] d;
      sw = 10'h155;
      wait_clks(10);
      peek(SD, d);
      n_checks++;
      if (d !== 32'h155) begin n_fail++; $display("FAIL sw_sdata got %h want %h", d, 32'h155); end
      peek(SC, d);
      n_checks++;
      if (d !== 32'h1) begin n_fail++; $display("FAIL sw_sctrl got %h want %h", d, 32'h1); end
      rd_strobe(SD, d);
      n_checks++;
      if (d !== 32'h155) begin n_fail++; $display("FAIL sw_read got %h want %h", d, 32'h155); end
      peek(SC, d);
      n_checks++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL sw_sctrl_after_read got %h want %h", d, 32'h0); end
   endtask

   task automatic test_key_bounce();
      logic [31:0] d;
      for (int i = 0; i < 5; i++) begin
         key_n = (i % 2 == 0) ? 4'hE : 4'hF;
         repeat (2) @(posedge clk);
      end
      #1;
      peek(KD, d);
      n_checks++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL bounce_kdata_early got %h want %h", d, 32'h0); end
      wait_clks(10);
      peek(KD, d);
      n_checks++;
      if (d !== 32'h1) begin n_fail++; $display("FAIL bounce_kdata got %h want %h", d, 32'h1); end
      peek(KC, d);
      n_checks++;
      if (d !== 32'h1) begin n_fail++; $display("FAIL bounce_one_event got %h want %h", d, 32'h1); end
   endtask

   task automatic test_overrun();
      logic [31:0] d;
      rd_strobe(KD, d);
      key_n = 4'hF;
      wait_clks(10);
      peek(KC, d);
      n_checks++;
      if (d !== 32'h1) begin n_fail++; $display("FAIL ovr_release_kctrl got %h want %h", d, 32'h1); end
      key_n = 4'hE;
      wait_clks(10);
      peek(KC, d);
      n_checks++;
      if (d !== 32'h5) begin n_fail++; $display("FAIL ovr_set got %h want %h", d, 32'h5); end
      wr_strobe(KC, 32'h4);
      peek(KC, d);
      n_checks++;
      if (d !== 32'h5) begin n_fail++; $display("FAIL ovr_write1_ignored got %h want %h", d, 32'h5); end
      wr_strobe(KD, 32'h0);
      peek(KD, d);
      n_checks++;
      if (d !== 32'h1) begin n_fail++; $display("FAIL kdata_write_ignored got %h want %h", d, 32'h1); end
      wr_strobe(KC, 32'h0);
      peek(KC, d);
      n_checks++;
      if (d !== 32'h1) begin n_fail++; $display("FAIL ovr_clear got %h want %h", d, 32'h1); end
   endtask

   task automatic test_irq();
      logic [31:0] d;
      bit seen = 0;
      wr_strobe(SC, 32'h100);
      peek(SC, d);
      n_checks++;
      if (d !== 32'h100) begin n_fail++; $display("FAIL irq_sie got %h want %h", d, 32'h100); end
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_idle got %b want 0", irq); end
      sw = 10'h2AA;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (irq === 1'b1) seen = 1;
      end
      peek(SC, d);
      n_checks++;
      if (!seen || d !== 32'h101) begin n_fail++; $display("FAIL irq_rise seen %0d sctrl %h want %h", seen, d, 32'h101); end
      rd_strobe(SD, d);
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_drop got %b want 0", irq); end
      n_checks++;
      if (d !== 32'h2AA) begin n_fail++; $display("FAIL irq_sdata got %h want %h", d, 32'h2AA); end
   endtask

   task automatic test_simul_and_unmapped();
      logic [31:0] d;
      bit seen = 0;
      @(negedge clk);
      bus.addr = KD; bus.rd = 1'b1;
      key_n = 4'hF;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk); #1;
         if (bus.rdata === 32'h0) seen = 1;
      end
      bus.rd = 1'b0;
      peek(KC, d);
      n_checks++;
      if (!seen || d !== 32'h1) begin n_fail++; $display("FAIL set_wins seen %0d kctrl %h want %h", seen, d, 32'h1); end
      peek(32'hFFFF_F088, d);
      n_checks++;
      if (bus.hit !== 1'b0 || d !== 32'h0) begin n_fail++; $display("FAIL unmapped hit %b rdata %h want 0/0", bus.hit, d); end
      peek(SD, d);
      n_checks++;
      if (bus.hit !== 1'b1) begin n_fail++; $display("FAIL mapped_hit got %b want 1", bus.hit); end
   endtask

   task automatic test_reset_midrun();
      logic [31:0] d;
      sw = 10'h0F0;
      wait_clks(10);
      n_checks++;
      if (irq !== 1'b1) begin n_fail++; $display("FAIL pre_reset_irq got %b want 1", irq); end
      @(negedge clk); #1;
      reset = 1'b1;
      #1;
      n_checks++;
      if (irq !== 1'b0) begin n_fail++; $display("FAIL midreset_irq got %b want 0", irq); end
      peek(SD, d);
      n_checks++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL midreset_sdata got %h want %h", d, 32'h0); end
      peek(KC, d);
      n_checks++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL midreset_kctrl got %h want %h", d, 32'h0); end
      wait_clks(2);
      @(negedge clk) reset = 1'b0;
      wait_clks(10);
      peek(SD, d);
      n_checks++;
      if (d !== 32'h0F0) begin n_fail++; $display("FAIL post_reset_sdata got %h want %h", d, 32'h0F0); end
      peek(SC, d);
      n_checks++;
      if (d !== 32'h1) begin n_fail++; $display("FAIL post_reset_sctrl got %h want %h", d, 32'h1); end
   endtask

   initial begin
      test_reset_initial();
      test_sw_data();
      test_key_bounce();
      test_overrun();
      test_irq();
      test_simul_and_unmapped();
      test_reset_midrun();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
